// File: rtl/inst_encoder.sv
// Two-stage valid/ready encoder: packs decoded RV32I fields plus a signed
// immediate into an instruction word, flagging immediates that do not fit.
module inst_encoder #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [6:0]         in_opcode,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [2:0]         in_funct3,
   input  logic [6:0]         in_funct7,
   input  logic [31:0]        in_imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_inst,
   output logic               out_err,
   output logic [COUNT_W-1:0] enc_count,
   output logic [COUNT_W-1:0] err_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        s1_valid;
   logic [6:0]  s1_opcode;
   logic [4:0]  s1_rd, s1_rs1, s1_rs2;
   logic [2:0]  s1_funct3;
   logic [6:0]  s1_funct7;
   logic [31:0] s1_imm;

   logic        s1_adv, s2_adv;
   logic [31:0] enc_inst;
   logic        enc_err;
   logic        fit_i, fit_b, fit_j;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Sign-extension checks: the top bits must all equal the format's sign bit.
   assign fit_i = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
   assign fit_b = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
   assign fit_j = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

   always_comb begin
      enc_inst = NOP;
      enc_err  = 1'b1;
      case (s1_opcode)
         7'b0000011, 7'b1100111, 7'b0010011: begin
            if (s1_opcode == 7'b0010011 && (s1_funct3 == 3'b001 || s1_funct3 == 3'b101)) begin
               enc_inst = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
               enc_err  = |s1_imm[31:5];
            end else begin
               enc_inst = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
               enc_err  = !fit_i;
            end
         end
         7'b0100011: begin
            enc_inst = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            enc_err  = !fit_i;
         end
         7'b1100011: begin
            enc_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                        s1_imm[4:1], s1_imm[11], s1_opcode};
            enc_err  = s1_imm[0] || !fit_b;
         end
         7'b1101111: begin
            enc_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
            enc_err  = s1_imm[0] || !fit_j;
         end
         7'b0110111, 7'b0010111: begin
            enc_inst = {s1_imm[31:12], s1_rd, s1_opcode};
            enc_err  = |s1_imm[11:0];
         end
         7'b0110011: begin
            enc_inst = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            enc_err  = 1'b0;
         end
         default: begin
            enc_inst = NOP;
            enc_err  = 1'b1;
         end
      endcase
      if (enc_err) enc_inst = NOP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_opcode <= '0;
         s1_rd     <= '0;
         s1_rs1    <= '0;
         s1_rs2    <= '0;
         s1_funct3 <= '0;
         s1_funct7 <= '0;
         s1_imm    <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_opcode <= in_opcode;
            s1_rd     <= in_rd;
            s1_rs1    <= in_rs1;
            s1_rs2    <= in_rs2;
            s1_funct3 <= in_funct3;
            s1_funct7 <= in_funct7;
            s1_imm    <= in_imm;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_err   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_inst <= enc_inst;
            out_err  <= enc_err;
         end
      end
   end

   // Counters saturate so a long self-test never wraps back to a small value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (out_valid && out_ready) begin
         if (out_err) begin
            if (err_count != {COUNT_W{1'b1}}) err_count <= err_count + 1'b1;
         end else begin
            if (enc_count != {COUNT_W{1'b1}}) enc_count <= enc_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: driver queues expected words, a negedge
// monitor pops and compares on every output transfer.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready, in_ready_s;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid, out_valid_s;
   logic        out_ready = 1'b1;
   logic [31:0] out_inst, out_inst_s;
   logic        out_err, out_err_s;
   logic [15:0] enc_count, err_count;
   logic [1:0]  enc_count_s, err_count_s;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];
   int enc_m = 0;
   int err_m = 0;

   always #5 clk = ~clk;

   inst_encoder #(.COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
   );

   inst_encoder #(.COUNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_inst(out_inst_s),
      .out_err(out_err_s), .enc_count(enc_count_s), .err_count(err_count_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic check_counts(input string tag);
      chk({tag, " enc_count"}, {16'h0, enc_count}, sat(enc_m, 65535));
      chk({tag, " err_count"}, {16'h0, err_count}, sat(err_m, 65535));
      chk({tag, " enc_count_w2"}, {30'h0, enc_count_s}, sat(enc_m, 3));
      chk({tag, " err_count_w2"}, {30'h0, err_count_s}, sat(err_m, 3));
   endtask

   // Monitor: one line per output transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got inst %h err %b expected none", out_inst, out_err);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               $display("out inst=%h err=%b", out_inst, out_err);
               chk("out_inst", out_inst, e[31:0]);
               chk("out_err", {31'h0, out_err}, {31'h0, e[32]});
               chk("out_inst_w2", out_inst_s, e[31:0]);
               if (e[32]) err_m++;
               else enc_m++;
            end
         end
      end
   end

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic err, input logic [31:0] inst);
      bit ok;
      int budget;
      in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      budget = 0;
      forever begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         if (ok) break;
         budget++;
         if (budget > 200) begin
            $display("FAIL send_timeout: got in_ready 0 expected 1");
            errors++;
            checks++;
            break;
         end
      end
      if (ok) exp_q.push_back({err, inst});
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " drain_left"}, exp_q.size(), 0);
      @(negedge clk);
      check_counts(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("reset out_valid", {31'h0, out_valid}, 0);
      chk("reset out_inst", out_inst, 0);
      chk("reset out_err", {31'h0, out_err}, 0);
      check_counts("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic formats
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0093);
      send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,        1'b0, 32'h0020_A423);
      send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd4,      1'b0, 32'hFE00_0EE3);
      send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEAD_BEEF, 1'b0, 32'h0020_81B3);
      send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8,        1'b0, 32'h0080_006F);
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2047,     1'b0, 32'h7FF0_0093);
      send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4094,     1'b0, 32'h7E00_0FE3);
      drain("formats");

      // Errors
      send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,        1'b1, 32'h0000_0013);
      send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096,     1'b1, 32'h0000_0013);
      send(7'b1110011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0,        1'b1, 32'h0000_0013);
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     1'b1, 32'h0000_0013);
      drain("errors");

      // Shifts and U-type
      send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd31,        1'b0, 32'h01F0_9093);
      send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32,        1'b1, 32'h0000_0013);
      send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd3,   1'b0, 32'h4030_D093);
      send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
      send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001, 1'b1, 32'h0000_0013);
      drain("shift_u");

      // Backpressure: two accepted, third waits, output word holds steady
      out_ready = 1'b0;
      send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0, 32'h0050_0113);
      send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd6, 1'b0, 32'h0060_0193);
      fork
         send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp in_ready", {31'h0, in_ready}, 0);
               chk("bp out_valid", {31'h0, out_valid}, 1);
               chk("bp out_inst_hold", out_inst, 32'h0050_0113);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp consecutive out_valid", {31'h0, out_valid}, 1);
            end
         end
      join
      drain("backpressure");

      // Reset with both stages full
      out_ready = 1'b0;
      send(7'b0010011, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b0, 32'h0010_0393);
      send(7'b0010011, 5'd8, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 1'b0, 32'h0020_0413);
      @(negedge clk);
      chk("full out_valid", {31'h0, out_valid}, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      enc_m = 0;
      err_m = 0;
      chk("async rst out_valid", {31'h0, out_valid}, 0);
      check_counts("async_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("post rst out_valid", {31'h0, out_valid}, 0);
      @(posedge clk); #1;

      // Saturation of the narrow counters
      for (int k = 0; k < 5; k++)
         send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b0, 32'h0020_81B3);
      drain("saturate");
      repeat (2) @(negedge clk);
      chk("sat enc_count_w2 hold", {30'h0, enc_count_s}, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the immediate generator. Takes decoded instruction fields plus a 32-bit signed immediate. Checks that the immediate fits the format selected by the opcode, then packs everything into a 32-bit RV32I instruction word. It is a 2-stage valid/ready pipeline that feeds the instruction-memory loader and self-test sequencer. It also keeps counters of encoded and rejected instructions.

Parameters:
COUNT_W, 16, width of enc_count and err_count (saturating).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept the input this cycle
in_opcode  input  7  instruction opcode [6:0]
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R-type and shift-immediate only)
in_imm  input  32  signed immediate, byte offset for branches and jumps
out_valid  output  1  out_inst and out_err valid
out_ready  input  1  consumer accepts the output
out_inst  output  32  encoded instruction
out_err  output  1  immediate out of range, misaligned, or opcode unsupported
enc_count  output  COUNT_W  outputs accepted with out_err=0
err_count  output  COUNT_W  outputs accepted with out_err=1

Behaviour:
- Reset, asynchronous: both stage valids=0, out_valid=0, out_inst=0, out_err=0, counters=0. Asserting reset mid-operation discards in-flight items.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- S1 registers the fields and computes the format and error check. S2 registers the packed word and the error flag.
- Latency and throughput: 2 cycles from input transfer to out_valid when unstalled; one instruction per cycle sustained.
- Stall logic: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. This is purely combinational from out_ready with no extra bubble.
- While out_valid && !out_ready, out_inst and out_err hold stable. Output order equals input order.
- Common fields: [6:0]=opcode, [11:7]=rd, [14:12]=funct3, [19:15]=rs1, [24:20]=rs2, used only where the format has them.
- I-type (0000011, 1100111, 0010011):
  - [31:20]=imm[11:0].
  - Error unless imm is in -2048..2047, i.e. imm[31:11] are all equal.
  - Exception: opcode 0010011 with funct3 001 or 101 is a shift. Then [31:25]=funct7 and [24:20]=imm[4:0]; error unless imm is in 0..31.
- S-type (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range as I-type.
- B-type (1100011):
  - [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - Error if imm[0]=1 or imm is outside -4096..4094.
- JAL (1101111):
  - [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Error if imm[0]=1 or imm is outside -1048576..1048574.
- U-type (0110111, 0010111): [31:12]=imm[31:12]. Error if imm[11:0] is not 0.
- R-type (0110011): [31:25]=funct7. Immediate ignored, never an error.
- Any other opcode is an error.
- On error: out_inst=32'h00000013 (canonical NOP), out_err=1.
- Counters: updated on output transfer only. enc_count increments when out_err=0, err_count when out_err=1. Each saturates at all-ones.
- Simultaneous input and output transfer with both stages full: legal, and the pipeline shifts.

Test Plan:
1. Load 0010011 with rd=1, rs1=0, f3=000, imm=32'hFFFFFFFF, out_ready=1 -> out_valid two cycles later, out_inst=32'hFFF00093, out_err=0, enc_count=1.
2. Load 0100011 with rs1=1, rs2=2, f3=010, imm=8 -> out_inst=32'h0020A423. Then load 1100011 with rs1=rs2=0, f3=000, imm=-4 -> out_inst=32'hFE000EE3.
3. Error cases:
   - 1101111 with imm=3 -> out_err=1, out_inst=32'h00000013.
   - 1100011 with imm=4096 -> error.
   - Opcode 1110011 -> error.
   - Expected totals: err_count=3, enc_count unchanged.
4. Backpressure: hold out_ready=0 while offering 3 back-to-back valid inputs -> exactly 2 accepted, then in_ready=0, and out_inst stays stable. Release out_ready -> all 3 emerge in order on consecutive cycles.
5. Shift and U-type:
   - 0010011 with f3=001, funct7=0, imm=31 -> accepted; with imm=32 -> error.
   - 0110111 with rd=5, imm=32'h12345000 -> out_inst=32'h123452B7.
   - 0110111 with imm=32'h12345001 -> error.
6. Reset and saturation:
   - Assert rst_n low with both stages full -> out_valid=0 and counters=0 immediately, and nothing from before reset emerges afterwards.
   - With COUNT_W=2, 5 good outputs -> enc_count=3 and stays there.
